ascon_round_scheduler: RTL and testbench
========================================

# ascon_round_scheduler

Sequencing controller for the ASCON permutation datapath. It accepts a permutation command (p12 or p6) and drives the 4-bit round counter's control inputs (enable, init-to-0, init-to-6). It also drives the state-register load/select strobes for one round per cycle, reports the active round index, and pulses completion. It sits between the AEAD mode FSM, which issues commands, and the round counter plus permutation/state register.

## Interface
- `P6_FIRST`, default 6: first round index of p6; the counter's init_b value.
- `LAST_ROUND`, default 11: index of the final round for both modes.
- `clock_i` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: command request, sampled when `ready_o`=1.
- `mode_i` in 1: 0 = p12 (rounds 0..11), 1 = p6 (rounds 6..11); sampled with `start_i`.
- `abort_i` in 1: synchronous cancel; highest priority after reset.
- `ready_o` out 1: block idle, command accepted this cycle if `start_i`=1.
- `busy_o` out 1: command in progress (RUN or DONE).
- `en_cpt_o` out 1: round counter enable.
- `init_a_o` out 1: counter load 0 (p12 start).
- `init_b_o` out 1: counter load `P6_FIRST` (p6 start).
- `en_reg_state_o` out 1: state register load enable.
- `sel_state_o` out 1: 0 = load from external input, 1 = feedback from permutation output.
- `round_o` out 4: current round index (internal mirror of the counter), for round-constant selection.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE. Internal 4-bit register `round_q` mirrors the external counter exactly.
- IDLE:
  - `ready_o` = !`abort_i`.
  - On `start_i`=1 and `abort_i`=0: `en_cpt_o`=1, `init_a_o`=!`mode_i`, `init_b_o`=`mode_i`.
  - `round_q` loads 0 (p12) or `P6_FIRST` (p6). Next state is RUN.
  - Otherwise all control outputs are 0.
- RUN:
  - `en_reg_state_o`=1.
  - `sel_state_o`=0 on the first RUN cycle only, 1 on every later RUN cycle.
  - `round_o`=`round_q`.
  - If `round_q` != `LAST_ROUND`: `en_cpt_o`=1 (increment), `round_q`++, stay in RUN.
  - If `round_q` = `LAST_ROUND`: `en_cpt_o`=0 (counter holds at 11), next state DONE.
- DONE: `done_o`=1, `en_reg_state_o`=0, `en_cpt_o`=0. Next state IDLE.
- `init_a_o` and `init_b_o` are never 1 simultaneously. Both are 0 outside the accepting IDLE cycle.
- `abort_i`=1 in RUN or DONE:
  - All strobes are forced to 0 that cycle, including `done_o`.
  - Next state IDLE. `round_q` holds.
  - The aborted command produces no `done_o`.
- `start_i` outside IDLE is ignored and not queued.
- Counter width is 4 bits. `round_q` never exceeds `LAST_ROUND`, so there is no wrap.

## Timing
- Reset values:
  - State IDLE, `round_q`=0, `round_o`=0.
  - `ready_o`=1, all other outputs 0.
- All outputs are combinational from state, `round_q` and inputs. There is no output register.
- Accept cycle is C0.
- p12: RUN C1..C12 with `round_o` 0..11; `done_o` at C13; `ready_o` at C14.
- p6: RUN C1..C6 with `round_o` 6..11; `done_o` at C7; `ready_o` at C8.
- A new command is accepted at the earliest in the cycle after DONE. There is no overlap with DONE.
- Asserting `reset_i` mid-RUN returns the block to reset values immediately (asynchronous), with no `done_o`.

## Test plan
- Reset: assert `reset_i` → `ready_o`=1, `busy_o`=0, `round_o`=0, all strobes 0. Strobes stay 0 with `start_i`=0.
- p12: `start_i`=1, `mode_i`=0 at C0 →
  - C0: `init_a_o`=1, `en_cpt_o`=1.
  - C1..C12: `round_o` 0..11.
  - `sel_state_o`=0 only at C1.
  - `en_cpt_o`=0 at C12.
  - `done_o` exactly at C13.
- p6: `start_i`=1, `mode_i`=1 at C0 →
  - C0: `init_b_o`=1.
  - C1..C6: `round_o` 6..11.
  - `done_o` at C7.
  - `ready_o`=1 at C8.
- Start while busy: pulse `start_i` at C3 of a p12 command → ignored, round sequence unchanged, exactly one `done_o`.
- Abort: `abort_i`=1 at C5 of p12 → at C5 all strobes are 0; C6 is IDLE with `ready_o`=1; no `done_o`. A subsequent p6 command completes normally.
- Async reset: assert `reset_i` mid-clock at round 4 → outputs take reset values before the next edge; after release, a p12 command runs from round 0.

Source files
------------

// File: rtl/ascon_round_scheduler_if.sv
// Command/strobe bundle between the AEAD mode FSM, the ASCON round scheduler
// and the round counter / state register it steers.
interface ascon_round_scheduler_if;
  logic       start_i;
  logic       mode_i;
  logic       abort_i;
  logic       ready_o;
  logic       busy_o;
  logic       en_cpt_o;
  logic       init_a_o;
  logic       init_b_o;
  logic       en_reg_state_o;
  logic       sel_state_o;
  logic [3:0] round_o;
  logic       done_o;

  modport master (
    output start_i, mode_i, abort_i,
    input  ready_o, busy_o, en_cpt_o, init_a_o, init_b_o,
    input  en_reg_state_o, sel_state_o, round_o, done_o
  );

  modport slave (
    input  start_i, mode_i, abort_i,
    output ready_o, busy_o, en_cpt_o, init_a_o, init_b_o,
    output en_reg_state_o, sel_state_o, round_o, done_o
  );
endinterface

// File: rtl/ascon_round_scheduler.sv
// Round sequencer for the ASCON permutation: runs p12 (rounds 0..11) or
// p6 (rounds 6..11), one round per cycle, steering counter and state register.
module ascon_round_scheduler #(
  parameter logic [3:0] P6_FIRST   = 4'd6,
  parameter logic [3:0] LAST_ROUND = 4'd11
) (
  input logic                     clock_i,
  input logic                     reset_i,
  ascon_round_scheduler_if.slave  sched
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] round_r;
  logic       first_r;

  logic       ready_s;
  logic       busy_s;
  logic       en_cpt_s;
  logic       init_a_s;
  logic       init_b_s;
  logic       en_reg_state_s;
  logic       sel_state_s;
  logic       done_s;

  // Sequencer state; round_r tracks the external counter value exactly.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      round_r <= 4'd0;
      first_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sched.start_i && !sched.abort_i) begin
            state_r <= ST_RUN;
            round_r <= sched.mode_i ? P6_FIRST : 4'd0;
            first_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            first_r <= 1'b0;
          end
        end
        ST_RUN: begin
          first_r <= 1'b0;
          if (sched.abort_i) begin
            state_r <= ST_IDLE;
          end else if (round_r != LAST_ROUND) begin
            round_r <= round_r + 4'd1;
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          first_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          first_r <= 1'b0;
        end
      endcase
    end
  end

  // Strobe decode; abort silences every strobe in the cycle it is seen.
  always_comb begin
    ready_s        = 1'b0;
    busy_s         = 1'b0;
    en_cpt_s       = 1'b0;
    init_a_s       = 1'b0;
    init_b_s       = 1'b0;
    en_reg_state_s = 1'b0;
    sel_state_s    = 1'b0;
    done_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = !sched.abort_i;
        if (sched.start_i && !sched.abort_i) begin
          en_cpt_s = 1'b1;
          init_a_s = !sched.mode_i;
          init_b_s = sched.mode_i;
        end else begin
          en_cpt_s = 1'b0;
        end
      end
      ST_RUN: begin
        busy_s = 1'b1;
        if (!sched.abort_i) begin
          en_reg_state_s = 1'b1;
          // First round loads the external state, later rounds feed back.
          sel_state_s    = !first_r;
          en_cpt_s       = (round_r != LAST_ROUND);
        end else begin
          en_reg_state_s = 1'b0;
        end
      end
      ST_DONE: begin
        busy_s = 1'b1;
        if (!sched.abort_i) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  assign sched.ready_o        = ready_s;
  assign sched.busy_o         = busy_s;
  assign sched.en_cpt_o       = en_cpt_s;
  assign sched.init_a_o       = init_a_s;
  assign sched.init_b_o       = init_b_s;
  assign sched.en_reg_state_o = en_reg_state_s;
  assign sched.sel_state_o    = sel_state_s;
  assign sched.round_o        = round_r;
  assign sched.done_o         = done_s;

endmodule

// File: tb/tb_ascon_round_scheduler.sv
// Self-checking bench: directed scenarios plus random commands/aborts,
// compared cycle by cycle against a queue-based round-list model.
module tb_ascon_round_scheduler;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;

  ascon_round_scheduler_if ifc ();

  ascon_round_scheduler #(.P6_FIRST(4'd6), .LAST_ROUND(4'd11)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .sched   (ifc.slave)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int done_seen = 0;
  int last_done_cyc = -1;
  int acc_cyc  = 0;

  // Model: pending round list of the running command
  bit       m_active;
  bit       m_first;
  bit       m_done;
  int       m_q[$];
  int       m_round;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_first  = 1'b0;
    m_done   = 1'b0;
    m_q.delete();
    m_round  = 0;
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, update model at posedge.
  task automatic step(input bit st, input bit md, input bit ab);
    bit e_ready, e_busy, e_cpt, e_ia, e_ib, e_reg, e_sel, e_done;
    int e_round;
    ifc.start_i = st;
    ifc.mode_i  = md;
    ifc.abort_i = ab;
    #1;
    e_ready = 0; e_cpt = 0; e_ia = 0; e_ib = 0; e_reg = 0; e_sel = 0; e_done = 0;
    e_busy  = m_active || m_done;
    e_round = m_round;
    if (m_done) begin
      e_done = !ab;
    end else if (m_active) begin
      e_round = m_q[0];
      if (!ab) begin
        e_reg = 1;
        e_sel = !m_first;
        e_cpt = (m_q.size() > 1);
      end
    end else begin
      e_ready = !ab;
      if (st && !ab) begin
        e_cpt = 1;
        e_ia  = !md;
        e_ib  = md;
      end
    end
    chk("ready",  32'(ifc.ready_o),        32'(e_ready));
    chk("busy",   32'(ifc.busy_o),         32'(e_busy));
    chk("en_cpt", 32'(ifc.en_cpt_o),       32'(e_cpt));
    chk("init_a", 32'(ifc.init_a_o),       32'(e_ia));
    chk("init_b", 32'(ifc.init_b_o),       32'(e_ib));
    chk("en_reg", 32'(ifc.en_reg_state_o), 32'(e_reg));
    chk("sel",    32'(ifc.sel_state_o),    32'(e_sel));
    chk("round",  32'(ifc.round_o),        32'(e_round));
    chk("done",   32'(ifc.done_o),         32'(e_done));
    chk("init_excl", 32'(ifc.init_a_o & ifc.init_b_o), 32'd0);
    if (ifc.done_o === 1'b1) begin
      done_seen++;
      last_done_cyc = cyc;
    end
    if (ifc.ready_o === 1'b1 && st && !ab) acc_cyc = cyc;
    @(posedge clock_i);
    if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (ab) begin
        m_active = 0;
        m_q.delete();
      end else begin
        void'(m_q.pop_front());
        m_first = 0;
        if (m_q.size() == 0) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_round = m_q[0];
        end
      end
    end else if (st && !ab) begin
      m_q.delete();
      for (int r = (md ? 6 : 0); r <= 11; r++) m_q.push_back(r);
      m_round  = md ? 6 : 0;
      m_active = 1;
      m_first  = 1;
    end
    cyc++;
    @(negedge clock_i);
  endtask

  task automatic run_cmd(input bit md, input int idle_after);
    step(1'b1, md, 1'b0);
    for (int i = 0; i < (md ? 7 : 13) + idle_after; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ifc.start_i = 1'b0;
    ifc.mode_i  = 1'b0;
    ifc.abort_i = 1'b0;
    model_reset();
    #2;
    chk("rst_ready",  32'(ifc.ready_o),  32'd1);
    chk("rst_busy",   32'(ifc.busy_o),   32'd0);
    chk("rst_round",  32'(ifc.round_o),  32'd0);
    chk("rst_en_cpt", 32'(ifc.en_cpt_o), 32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // p12 and p6 with latency checks
    done_seen = 0;
    run_cmd(1'b0, 1);
    chk("p12_latency", 32'(last_done_cyc - acc_cyc), 32'd13);
    chk("p12_dones", 32'(done_seen), 32'd1);
    done_seen = 0;
    run_cmd(1'b1, 1);
    chk("p6_latency", 32'(last_done_cyc - acc_cyc), 32'd7);
    chk("p6_dones", 32'(done_seen), 32'd1);

    // start pulse while busy is ignored
    done_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    chk("busy_start_dones", 32'(done_seen), 32'd1);
    chk("busy_start_latency", 32'(last_done_cyc - acc_cyc), 32'd13);

    // abort at C5, then p6 completes
    done_seen = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0);
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run_cmd(1'b1, 1);
    chk("post_abort_p6", 32'(done_seen), 32'd1);

    // async reset mid-run at round 4
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_round", 32'(ifc.round_o), 32'd4);
    #1;
    reset_i = 1'b1;
    #1;
    chk("arst_ready",  32'(ifc.ready_o),        32'd1);
    chk("arst_busy",   32'(ifc.busy_o),         32'd0);
    chk("arst_round",  32'(ifc.round_o),        32'd0);
    chk("arst_en_reg", 32'(ifc.en_reg_state_o), 32'd0);
    chk("arst_en_cpt", 32'(ifc.en_cpt_o),       32'd0);
    chk("arst_done",   32'(ifc.done_o),         32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    model_reset();
    done_seen = 0;
    run_cmd(1'b0, 1);
    chk("post_rst_p12", 32'(last_done_cyc - acc_cyc), 32'd13);
    chk("post_rst_dones", 32'(done_seen), 32'd1);

    // randomized commands and aborts
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) == 0, $urandom % 2, ($urandom % 16) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
